// File: rtl/spu_even_pkg.sv
// Shared types and constants for the even-pipe issue scheduler.
// Unit IDs, scoreboard geometry and the latency clamp live here.
package spu_even_pkg;

  localparam int SB_DEPTH = 7;
  localparam int MAX_LAT  = 7;
  localparam int REG_W    = 7;
  localparam int LAT_W    = 3;

  localparam logic [2:0] UNIT_FX1    = 3'd0;
  localparam logic [2:0] UNIT_FX2    = 3'd1;
  localparam logic [2:0] UNIT_SP     = 3'd2;
  localparam logic [2:0] UNIT_BYTE   = 3'd3;
  localparam logic [2:0] UNIT_BUBBLE = 3'd7;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic [LAT_W-1:0] lat;
  } sb_entry_t;

  function automatic logic [LAT_W-1:0] clamp_lat(
    input logic [3:0] lat
  );
    logic [LAT_W-1:0] r;
    if (lat == 4'd0) begin
      r = 3'd1;
    end else if (lat > 4'(MAX_LAT)) begin
      r = 3'(MAX_LAT);
    end else begin
      r = lat[LAT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/even_scoreboard.sv
// Age-ordered write-tracking shift register with RAW compare.
// Entry k holds the writer fired k edges ago.
module even_scoreboard
  import spu_even_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [REG_W-1:0] push_dst_i,
  input  logic [LAT_W-1:0] push_lat_i,
  input  logic [REG_W-1:0] ra_addr_i,
  input  logic [REG_W-1:0] rb_addr_i,
  input  logic [REG_W-1:0] rc_addr_i,
  input  logic             ra_use_i,
  input  logic             rb_use_i,
  input  logic             rc_use_i,
  output logic             hazard_o
);

  sb_entry_t sb_q [1:SB_DEPTH];
  sb_entry_t sb_d [1:SB_DEPTH];

  function automatic logic src_hit(
    input logic [REG_W-1:0] addr,
    input logic             use_f,
    input sb_entry_t        e,
    input logic [LAT_W-1:0] age
  );
    return use_f && e.valid &&
           (e.dst == addr) &&
           (age < e.lat);
  endfunction

  // Shift every edge; the newest fire enters at entry 1.
  always_comb begin
    sb_d[1].valid = push_i;
    sb_d[1].dst   = push_dst_i;
    sb_d[1].lat   = push_lat_i;
    for (int k = 2; k <= SB_DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  // Scoreboard storage; reset forgets all in-flight writers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= SB_DEPTH; k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= SB_DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
    end
  end

  // A used source matching a young-enough writer is a hazard.
  always_comb begin
    hazard_o = 1'b0;
    for (int k = 1; k <= SB_DEPTH; k++) begin
      if (src_hit(ra_addr_i, ra_use_i,
                  sb_q[k], LAT_W'(k)) ||
          src_hit(rb_addr_i, rb_use_i,
                  sb_q[k], LAT_W'(k)) ||
          src_hit(rc_addr_i, rc_use_i,
                  sb_q[k], LAT_W'(k))) begin
        hazard_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/even_issue_sched.sv
// Even-pipe issue scheduler: handshake, issue register, stall count.
// EVEN_STALL_CNT_EN enables the saturating stall-cycle counter.
module even_issue_sched
  import spu_even_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_ra_addr,
  input  logic [REG_W-1:0] in_rb_addr,
  input  logic [REG_W-1:0] in_rc_addr,
  input  logic             in_ra_use,
  input  logic             in_rb_use,
  input  logic             in_rc_use,
  input  logic [REG_W-1:0] in_reg_dst,
  input  logic             in_reg_wr,
  input  logic [2:0]       in_unit_id,
  input  logic [3:0]       in_latency,
  input  logic [6:0]       in_instr_id,
  input  logic [31:0]      in_full_instr,
  output logic             out_valid,
  output logic [REG_W-1:0] out_reg_dst,
  output logic             out_reg_wr,
  output logic [2:0]       out_unit_id,
  output logic [3:0]       out_latency,
  output logic [6:0]       out_instr_id,
  output logic [31:0]      out_full_instr,
  output logic [31:0]      stall_cnt
);

  logic             hazard;
  logic             fire;
  logic [LAT_W-1:0] lat_eff;

  logic             valid_q,  valid_d;
  logic [REG_W-1:0] dst_q,    dst_d;
  logic             wr_q,     wr_d;
  logic [2:0]       unit_q,   unit_d;
  logic [3:0]       lat_q,    lat_d;
  logic [6:0]       id_q,     id_d;
  logic [31:0]      instr_q,  instr_d;

  assign in_ready = ~hazard;
  assign fire     = in_valid & in_ready;
  assign lat_eff  = clamp_lat(in_latency);

  even_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fire & in_reg_wr),
    .push_dst_i (in_reg_dst),
    .push_lat_i (lat_eff),
    .ra_addr_i  (in_ra_addr),
    .rb_addr_i  (in_rb_addr),
    .rc_addr_i  (in_rc_addr),
    .ra_use_i   (in_ra_use),
    .rb_use_i   (in_rb_use),
    .rc_use_i   (in_rc_use),
    .hazard_o   (hazard)
  );

  // Next issue slot: the fired instruction or a bubble.
  always_comb begin
    valid_d = 1'b0;
    dst_d   = '0;
    wr_d    = 1'b0;
    unit_d  = UNIT_BUBBLE;
    lat_d   = '0;
    id_d    = '0;
    instr_d = '0;
    if (fire) begin
      valid_d = 1'b1;
      dst_d   = in_reg_dst;
      wr_d    = in_reg_wr;
      unit_d  = in_unit_id;
      lat_d   = {1'b0, lat_eff};
      id_d    = in_instr_id;
      instr_d = in_full_instr;
    end
  end

  // Issue register driving the even pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      dst_q   <= '0;
      wr_q    <= 1'b0;
      unit_q  <= UNIT_BUBBLE;
      lat_q   <= '0;
      id_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      dst_q   <= dst_d;
      wr_q    <= wr_d;
      unit_q  <= unit_d;
      lat_q   <= lat_d;
      id_q    <= id_d;
      instr_q <= instr_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_reg_dst    = dst_q;
  assign out_reg_wr     = wr_q;
  assign out_unit_id    = unit_q;
  assign out_latency    = lat_q;
  assign out_instr_id   = id_q;
  assign out_full_instr = instr_q;

`ifdef EVEN_STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Count cycles where an offered instruction is held back.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && !in_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_even_issue_sched.sv
// Scoreboard bench for even_issue_sched: directed vectors,
// expected issues queued at send time, checked by a monitor.
module tb_even_issue_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_ra_addr, in_rb_addr, in_rc_addr;
  logic        in_ra_use, in_rb_use, in_rc_use;
  logic [6:0]  in_reg_dst;
  logic        in_reg_wr;
  logic [2:0]  in_unit_id;
  logic [3:0]  in_latency;
  logic [6:0]  in_instr_id;
  logic [31:0] in_full_instr;
  logic        out_valid;
  logic [6:0]  out_reg_dst;
  logic        out_reg_wr;
  logic [2:0]  out_unit_id;
  logic [3:0]  out_latency;
  logic [6:0]  out_instr_id;
  logic [31:0] out_full_instr;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  even_issue_sched dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ra_addr     (in_ra_addr),
    .in_rb_addr     (in_rb_addr),
    .in_rc_addr     (in_rc_addr),
    .in_ra_use      (in_ra_use),
    .in_rb_use      (in_rb_use),
    .in_rc_use      (in_rc_use),
    .in_reg_dst     (in_reg_dst),
    .in_reg_wr      (in_reg_wr),
    .in_unit_id     (in_unit_id),
    .in_latency     (in_latency),
    .in_instr_id    (in_instr_id),
    .in_full_instr  (in_full_instr),
    .out_valid      (out_valid),
    .out_reg_dst    (out_reg_dst),
    .out_reg_wr     (out_reg_wr),
    .out_unit_id    (out_unit_id),
    .out_latency    (out_latency),
    .out_instr_id   (out_instr_id),
    .out_full_instr (out_full_instr),
    .stall_cnt      (stall_cnt)
  );

  typedef struct {
    logic [6:0]  dst;
    logic        wr;
    logic [2:0]  unit;
    logic [3:0]  lat;
    logic [6:0]  id;
    logic [31:0] instr;
  } exp_t;

  exp_t        expq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_bub = 0;
  logic [31:0] exp_stall = 0;
  logic [6:0]  next_id = 7'd1;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h",
               name, got, req);
    end
  endtask

  task automatic send(
    input logic [6:0] dst, input logic wr,
    input logic [2:0] unit, input logic [3:0] lat,
    input logic [6:0] ra, input logic rau,
    input logic [6:0] rb, input logic rbu,
    input logic [6:0] rc, input logic rcu,
    input logic [3:0] elat, input int estall);
    int   stalls;
    bit   ok;
    exp_t e;
    stalls = 0;
    ok = 1'b0;
    in_reg_dst    = dst;
    in_reg_wr     = wr;
    in_unit_id    = unit;
    in_latency    = lat;
    in_ra_addr    = ra;
    in_ra_use     = rau;
    in_rb_addr    = rb;
    in_rb_use     = rbu;
    in_rc_addr    = rc;
    in_rc_use     = rcu;
    in_instr_id   = next_id;
    in_full_instr = {16'hA5C3, 9'd0, next_id};
    in_valid      = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    if (ok) begin
      e.dst   = dst;
      e.wr    = wr;
      e.unit  = unit;
      e.lat   = elat;
      e.id    = next_id;
      e.instr = {16'hA5C3, 9'd0, next_id};
      expq.push_back(e);
    end else begin
      in_valid = 1'b0;
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: id %0d got no ready, required ready",
               next_id);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_ra_use = 1'b0;
    in_rb_use = 1'b0;
    in_rc_use = 1'b0;
`ifdef EVEN_STALL_CNT_EN
    exp_stall = exp_stall + 32'(estall);
`endif
    chk($sformatf("stall_cycles id%0d", next_id),
        64'(stalls), 64'(estall));
    chk($sformatf("stall_cnt id%0d", next_id),
        64'(stall_cnt), 64'(exp_stall));
    next_id = next_id + 7'd1;
  endtask

  // Monitor: pop and compare on every issue, check bubbles otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_issue: got id %0d, required none",
                     out_instr_id);
          end else begin
            e = expq.pop_front();
            chk($sformatf("issue id%0d", e.id),
                64'({out_reg_dst, out_reg_wr, out_unit_id,
                     out_latency, out_instr_id, out_full_instr}),
                64'({e.dst, e.wr, e.unit, e.lat, e.id, e.instr}));
          end
        end else begin
          n_bub++;
          chk("bubble",
              64'({out_reg_dst, out_reg_wr, out_unit_id,
                   out_latency, out_instr_id, out_full_instr}),
              64'({7'd0, 1'b0, 3'd7, 4'd0, 7'd0, 32'd0}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0;
    in_ra_use = 1'b0; in_rb_use = 1'b0; in_rc_use = 1'b0;
    in_reg_dst = '0; in_reg_wr = 1'b0; in_unit_id = '0;
    in_latency = '0; in_instr_id = '0; in_full_instr = '0;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_unit", 64'(out_unit_id), 64'd7);
    chk("reset_reg_wr", 64'(out_reg_wr), 64'd0);
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // dst=5 L=2 then ra=5: one stall cycle
    send(7'd5, 1, 3'd0, 4'd2, 0,0, 0,0, 0,0, 4'd2, 0);
    send(7'd6, 1, 3'd1, 4'd2, 5,1, 0,0, 0,0, 4'd2, 1);
    // dst=9 L=7 then rc=9: six stall cycles
    send(7'd9, 1, 3'd1, 4'd7, 0,0, 0,0, 0,0, 4'd7, 0);
    send(7'd10,1, 3'd2, 4'd4, 0,0, 0,0, 9,1, 4'd4, 6);
    // non-writer producer, then unused-source match
    send(7'd3, 0, 3'd3, 4'd5, 0,0, 0,0, 0,0, 4'd5, 0);
    send(7'd13,1, 3'd0, 4'd1, 0,0, 3,1, 0,0, 4'd1, 0);
    send(7'd3, 1, 3'd3, 4'd5, 0,0, 0,0, 0,0, 4'd5, 0);
    send(7'd14,1, 3'd2, 4'd3, 0,0, 3,0, 0,0, 4'd3, 0);
    // register 0 is tracked like any other
    send(7'd0, 1, 3'd0, 4'd3, 0,0, 0,0, 0,0, 4'd3, 0);
    send(7'd15,1, 3'd1, 4'd2, 0,1, 0,0, 0,0, 4'd2, 2);
    // latency clamp 0 -> 1 and 15 -> 7
    send(7'd11,1, 3'd0, 4'd0, 0,0, 0,0, 0,0, 4'd1, 0);
    send(7'd16,1, 3'd3, 4'd2, 11,1, 0,0, 0,0, 4'd2, 0);
    send(7'd12,1, 3'd2, 4'd15, 0,0, 0,0, 0,0, 4'd7, 0);
    send(7'd17,1, 3'd1, 4'd2, 0,0, 12,1, 0,0, 4'd2, 6);

    // three idle cycles produce three bubbles
    b0 = n_bub;
    repeat (4) @(negedge clk);
    #1;
    chk("idle_bubbles", 64'(n_bub - b0), 64'd3);
    chk("idle_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    @(posedge clk);
    #1;

    // reset with three in-flight writers
    send(7'd20,1, 3'd0, 4'd7, 0,0, 0,0, 0,0, 4'd7, 0);
    send(7'd21,1, 3'd1, 4'd7, 0,0, 0,0, 0,0, 4'd7, 0);
    send(7'd22,1, 3'd2, 4'd7, 0,0, 0,0, 0,0, 4'd7, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_stall = 0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_reg_wr", 64'(out_reg_wr), 64'd0);
    chk("midrst_unit", 64'(out_unit_id), 64'd7);
    chk("midrst_fields",
        64'({out_reg_dst, out_latency, out_instr_id,
             out_full_instr}), 64'd0);
    chk("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(7'd23,1, 3'd3, 4'd2, 20,1, 21,1, 22,1, 4'd2, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/even_issue_sched.md
EVEN_ISSUE_SCHED -- requirements
Module: even_issue_sched

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset: asynchronous, active-high.
REQ-003 SHALL have port in_valid  input  1  decoded even-pipe instruction offered.
REQ-004 SHALL have port in_ready  output  1  scheduler accepts the instruction this cycle.
REQ-005 SHALL have ports in_ra_addr, in_rb_addr, in_rc_addr  input  7 each  source register numbers.
REQ-006 SHALL have ports in_ra_use, in_rb_use, in_rc_use  input  1 each  source actually read.
REQ-007 SHALL have ports in_reg_dst (7), in_reg_wr (1), in_unit_id (3), in_latency (4), in_instr_id (7), in_full_instr (32)  input  instruction fields.
REQ-008 SHALL have ports out_valid (1), out_reg_dst (7), out_reg_wr (1), out_unit_id (3), out_latency (4), out_instr_id (7), out_full_instr (32)  output  registered issue fields driving the even pipe.
REQ-009 SHALL have port stall_cnt  output  32  stall-cycle count.

Function
REQ-010 SHALL define fire = in_valid AND in_ready; only a fire enters the scoreboard.
REQ-011 SHALL clamp effective latency L: in_latency 0 -> 1, >7 -> 7, else unchanged.
REQ-012 SHALL keep a 7-entry age-ordered scoreboard; entry k (1..7) holds {valid, reg_dst, L} of the instruction fired k edges earlier, with valid = that fire AND in_reg_wr.
REQ-013 SHALL shift the scoreboard every clock edge; entry 1 loads the current fire (valid=0 when no fire); entry 7 content is discarded.
REQ-014 SHALL flag a RAW hazard when any used source equals reg_dst of a valid entry k with k < L of that entry.
REQ-015 SHALL drive in_ready = NOT hazard, combinationally, independent of in_valid.
REQ-016 SHALL compare register 0 like any other register (no hard-wired zero register).
REQ-017 SHALL on fire load out_* from in_* at the same edge and set out_valid=1, out_latency = clamped L.
REQ-018 SHALL on no fire issue a bubble: out_valid=0, out_reg_wr=0, out_unit_id=3'b111, other out_* zero.
REQ-019 SHALL give a one-cycle accept-to-issue latency; back-to-back independent instructions issue every cycle.
REQ-020 SHALL let a dependent instruction fire no earlier than exactly L edges after its producer's fire.
REQ-021 SHALL ignore entries whose in_reg_wr was 0 even if reg_dst matches.

Reset
REQ-022 SHALL on rst clear all scoreboard valids, drive out_valid=0, out_reg_wr=0, out_unit_id=3'b111, other out_* 0, stall_cnt 0.
REQ-023 SHALL abandon in-flight tracking on reset mid-operation; first post-reset instruction sees no hazard.

Configuration
REQ-024 SHALL with EVEN_STALL_CNT_EN defined increment stall_cnt on each cycle with in_valid=1 and in_ready=0, saturating at 32'hFFFFFFFF.
REQ-025 SHALL without EVEN_STALL_CNT_EN keep the stall_cnt port, tied to 0, with no counter logic.

Structure
REQ-026 SHALL place unit ID constants (FX1=0, FX2=1, SP=2, BYTE=3, BUBBLE=7), SB_DEPTH=7, MAX_LAT=7 and the scoreboard-entry typedef in package spu_even_pkg.
REQ-027 SHALL implement the shift register plus hazard compare as sub-module even_scoreboard; the top holds handshake, issue register and counter.

Verification
REQ-028 SHALL cover: fire dst=5 L=2, next cycle src ra=5 -> in_ready=0 one cycle, fires 2 edges after producer, stall_cnt=1.
REQ-029 SHALL cover: fire dst=9 L=7, dependent rc=9 held valid -> in_ready=0 six cycles, fires 7th edge, stall_cnt=6.
REQ-030 SHALL cover: producer in_reg_wr=0 dst=3, consumer rb=3 -> no stall; also in_rb_use=0 with match -> no stall.
REQ-031 SHALL cover: in_latency=0 and in_latency=15 -> out_latency 1 and 7, hazard windows 1 and 7 cycles.
REQ-032 SHALL cover: rst asserted with three in-flight writers -> outputs bubble values, stall_cnt=0, dependent of pre-reset producer fires first cycle after reset.
REQ-033 SHALL cover: in_valid=0 for 3 cycles -> three bubbles (out_valid=0, out_reg_wr=0, out_unit_id=7), stall_cnt unchanged.
